// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the time-multiplexed stereo mixer.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } state_t;

    typedef struct packed {
        logic        clip;
        logic [63:0] val;
    } sat_res_t;

    // Sum of CHANNELS full-scale OUT_W terms plus a sign bit of headroom.
    function automatic int acc_width(input int channels, input int out_w);
        return out_w + $clog2(channels) + 1;
    endfunction

    function automatic sat_res_t sat_signed(input logic signed [63:0] v, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (v < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end else begin
            r.val  = v;
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Combinational saturating narrow from a wide signed accumulator to OUT_W.
module audio_mix_sat
    import audio_mix_pkg::*;
#(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_clip
);

    sat_res_t          w_res;
    logic [63-OUT_W:0] w_unused_hi;

    always_comb begin
        w_res       = sat_signed(64'(i_val), OUT_W);
        o_val       = w_res.val[OUT_W-1:0];
        o_clip      = w_res.clip;
        w_unused_hi = w_res.val[63:OUT_W];
    end

endmodule

// File: rtl/audio_mix_core.sv
// Stereo mixer: snapshots N channels on ce_sample, accumulates one channel per clock
// through a shared multiplier, saturates and registers the result CHANNELS+1 clocks later.
module audio_mix_core
    import audio_mix_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 8,
    parameter int VOL_W    = 4,
    parameter int OUT_W    = 16
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce_sample,
    input  logic [CHANNELS*IN_W-1:0]  ch_in,
    input  logic [CHANNELS-1:0]       ch_signed,
    input  logic [CHANNELS*VOL_W-1:0] ch_vol,
    input  logic [CHANNELS*2-1:0]     ch_pan,
    input  logic                      mute,
    output logic [OUT_W-1:0]          out_l,
    output logic [OUT_W-1:0]          out_r,
    output logic                      out_valid,
    output logic                      clip_l,
    output logic                      clip_r,
    output logic                      busy,
    output logic                      overrun
);

    localparam int ACC_W  = acc_width(CHANNELS, OUT_W);
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = IN_W + VOL_W + 1;
    localparam int SHIFT  = OUT_W - IN_W - VOL_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [IN_W-1:0]  OFFSET   = {1'b1, {(IN_W-1){1'b0}}};

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_accept;
    logic [IDX_W-1:0]          r_idx;
    logic [CHANNELS*IN_W-1:0]  r_ch_in;
    logic [CHANNELS-1:0]       r_signed;
    logic [CHANNELS*VOL_W-1:0] r_vol;
    logic [CHANNELS*2-1:0]     r_pan;
    logic signed [ACC_W-1:0]   r_acc_l;
    logic signed [ACC_W-1:0]   r_acc_r;
    logic [OUT_W-1:0]          r_out_l;
    logic [OUT_W-1:0]          r_out_r;
    logic                      r_out_valid;
    logic                      r_clip_l;
    logic                      r_clip_r;
    logic                      r_overrun;

    logic [IN_W-1:0]           w_sel_in;
    logic [VOL_W-1:0]          w_sel_vol;
    logic signed [IN_W-1:0]    w_s;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_term;
    logic                      w_pan_l;
    logic                      w_pan_r;
    logic signed [OUT_W-1:0]   w_sat_l;
    logic signed [OUT_W-1:0]   w_sat_r;
    logic                      w_clip_l;
    logic                      w_clip_r;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ce_sample) begin
                    w_next   = ST_ACCUM;
                    w_accept = 1'b1;
                end
            end
            ST_ACCUM: if (r_idx == LAST_IDX) w_next = ST_SAT;
            ST_SAT:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Shared multiplier: offset-binary inputs are recentred by flipping the MSB.
    always_comb begin
        w_sel_in  = r_ch_in[r_idx*IN_W +: IN_W];
        w_sel_vol = r_vol[r_idx*VOL_W +: VOL_W];
        w_pan_l   = r_pan[2*r_idx];
        w_pan_r   = r_pan[2*r_idx+1];
        w_s       = r_signed[r_idx] ? w_sel_in : (w_sel_in ^ OFFSET);
        w_prod    = PROD_W'(w_s) * $signed(PROD_W'(w_sel_vol));
        w_term    = ACC_W'(w_prod) <<< SHIFT;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_ch_in     <= '0;
            r_signed    <= '0;
            r_vol       <= '0;
            r_pan       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_out_l     <= '0;
            r_out_r     <= '0;
            r_out_valid <= 1'b0;
            r_clip_l    <= 1'b0;
            r_clip_r    <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_overrun   <= ce_sample && (r_state != ST_IDLE);
            if (w_accept) begin
                r_ch_in  <= ch_in;
                r_signed <= ch_signed;
                r_vol    <= ch_vol;
                r_pan    <= ch_pan;
                r_acc_l  <= '0;
                r_acc_r  <= '0;
                r_idx    <= '0;
            end
            if (r_state == ST_ACCUM) begin
                if (w_pan_l) r_acc_l <= r_acc_l + w_term;
                if (w_pan_r) r_acc_r <= r_acc_r + w_term;
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ST_SAT) begin
                r_out_l     <= mute ? '0 : w_sat_l;
                r_out_r     <= mute ? '0 : w_sat_r;
                r_clip_l    <= w_clip_l && !mute;
                r_clip_r    <= w_clip_r && !mute;
                r_out_valid <= 1'b1;
            end
        end
    end

    audio_mix_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (
        .i_val  (r_acc_l),
        .o_val  (w_sat_l),
        .o_clip (w_clip_l)
    );

    audio_mix_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (
        .i_val  (r_acc_r),
        .o_val  (w_sat_r),
        .o_clip (w_clip_r)
    );

    assign out_l     = r_out_l;
    assign out_r     = r_out_r;
    assign out_valid = r_out_valid;
    assign clip_l    = r_clip_l;
    assign clip_r    = r_clip_r;
    assign busy      = (r_state != ST_IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_audio_mix_core.sv
// Bench for audio_mix_core with default parameters: vector table plus overrun and reset sequences.
module tb_audio_mix_core;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_sample;
    logic [31:0] ch_in;
    logic [3:0]  ch_signed;
    logic [15:0] ch_vol;
    logic [7:0]  ch_pan;
    logic        mute;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_valid;
    logic        clip_l;
    logic        clip_r;
    logic        busy;
    logic        overrun;

    always #5 clk_sys = ~clk_sys;

    audio_mix_core #(.CHANNELS(4), .IN_W(8), .VOL_W(4), .OUT_W(16)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_sample (ce_sample),
        .ch_in     (ch_in),
        .ch_signed (ch_signed),
        .ch_vol    (ch_vol),
        .ch_pan    (ch_pan),
        .mute      (mute),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid),
        .clip_l    (clip_l),
        .clip_r    (clip_r),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct {
        logic [31:0] ch;
        logic [3:0]  sgn;
        logic [15:0] vol;
        logic [7:0]  pan;
        logic        mte;
        logic [15:0] el;
        logic [15:0] er;
        logic        ecl;
        logic        ecr;
    } vec_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        cl;
        logic        cr;
        int          cyc;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    vec_t vecs[8];
    int   cyc    = 0;
    int   ov_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (out_valid) got_q.push_back('{out_l, out_r, clip_l, clip_r, cyc});
        if (overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        ch_in     = v.ch;
        ch_signed = v.sgn;
        ch_vol    = v.vol;
        ch_pan    = v.pan;
        mute      = v.mte;
    endtask

    // The strobe is captured on the posedge after this negedge, so that edge is cyc+1.
    task automatic push_exp(input vec_t v);
        exp_q.push_back('{v.el, v.er, v.ecl, v.ecr, cyc + 1});
    endtask

    task automatic strobe(input vec_t v);
        @(negedge clk_sys);
        drive(v);
        ce_sample = 1'b1;
        push_exp(v);
        @(negedge clk_sys);
        ce_sample = 1'b0;
        #1;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            #1;
            if (!busy && got_q.size() >= exp_q.size()) begin
                done = 1'b1;
                break;
            end
        end
        chk("completion_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_results(input string tag);
        res_t e;
        res_t g;
        chk({tag, "_valid_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_out_l"},   32'(g.l),  32'(e.l));
            chk({tag, "_out_r"},   32'(g.r),  32'(e.r));
            chk({tag, "_clip_l"},  32'(g.cl), 32'(e.cl));
            chk({tag, "_clip_r"},  32'(g.cr), 32'(e.cr));
            chk({tag, "_latency"}, 32'(g.cyc - e.cyc), 32'd5);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        vecs[0] = '{32'h808080FF, 4'h0, 16'hFFFF, 8'h01, 1'b0, 16'd30480, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 4'h0, 16'hFFFF, 8'hFF, 1'b0, 16'h7FFF,  16'h7FFF, 1'b1, 1'b1};
        vecs[2] = '{32'h00000000, 4'h0, 16'hFFFF, 8'hFF, 1'b0, 16'h8000,  16'h8000, 1'b1, 1'b1};
        vecs[3] = '{32'h80808080, 4'h1, 16'h0001, 8'h01, 1'b0, 16'hF800,  16'h0000, 1'b0, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 4'h0, 16'hFFFF, 8'hFF, 1'b1, 16'h0000,  16'h0000, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 4'h0, 16'h0000, 8'hFF, 1'b0, 16'h0000,  16'h0000, 1'b0, 1'b0};
        vecs[6] = '{32'hC04000FF, 4'hC, 16'h32FF, 8'h79, 1'b0, 16'h7310,  16'h9000, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 4'h0, 16'hFFFF, 8'h57, 1'b0, 16'h7FFF,  16'h7710, 1'b1, 1'b0};

        reset     = 1'b1;
        ce_sample = 1'b0;
        ch_in     = '0;
        ch_signed = '0;
        ch_vol    = '0;
        ch_pan    = '0;
        mute      = 1'b0;
        repeat (3) @(negedge clk_sys);
        #1;
        chk("rst_out_l",     32'(out_l),     32'd0);
        chk("rst_out_r",     32'(out_r),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_clip_l",    32'(clip_l),    32'd0);
        chk("rst_clip_r",    32'(clip_r),    32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            strobe(vecs[i]);
            chk($sformatf("vec%0d_busy_high", i), 32'(busy), 32'd1);
            wait_idle();
            check_results($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_busy_low", i), 32'(busy), 32'd0);
        end
        chk("no_spurious_overrun", 32'(ov_cnt), 32'd0);

        // Second strobe two clocks after the first is dropped; result reflects the first snapshot.
        @(negedge clk_sys);
        drive(vecs[0]);
        ce_sample = 1'b1;
        push_exp(vecs[0]);
        @(negedge clk_sys);
        ce_sample = 1'b0;
        @(negedge clk_sys);
        drive(vecs[1]);
        ce_sample = 1'b1;
        @(negedge clk_sys);
        ce_sample = 1'b0;
        #1;
        chk("overrun_pulse", 32'(overrun), 32'd1);
        @(negedge clk_sys);
        #1;
        chk("overrun_cleared", 32'(overrun), 32'd0);
        wait_idle();
        check_results("overrun");
        chk("overrun_count", 32'(ov_cnt), 32'd1);

        // Reset between accumulation edges aborts the sample.
        @(negedge clk_sys);
        drive(vecs[1]);
        ce_sample = 1'b1;
        @(negedge clk_sys);
        ce_sample = 1'b0;
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (10) @(negedge clk_sys);
        #1;
        chk("midrst_no_valid", 32'(got_q.size()), 32'd0);
        chk("midrst_out_l",    32'(out_l),  32'd0);
        chk("midrst_out_r",    32'(out_r),  32'd0);
        chk("midrst_clip_l",   32'(clip_l), 32'd0);
        chk("midrst_clip_r",   32'(clip_r), 32'd0);
        got_q.delete();

        strobe(vecs[6]);
        wait_idle();
        check_results("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_mix_core.md
# audio_mix_core

Parametrised, time-multiplexed audio mixer between the machine cores (PSG, tape monitor, future sound sources) and the `AUDIO_L`/`AUDIO_R` outputs of `emu`. It replaces fixed byte-duplication of a single 8-bit source. On each sample strobe it snapshots N channels and applies per-channel volume and L/R routing. It then accumulates one channel per clock, saturates to signed `OUT_W`, and presents a registered stereo sample with a valid pulse.

## Interface
**Parameters**
- `CHANNELS`, 4: number of input channels, ≥1.
- `IN_W`, 8: bits per channel sample.
- `VOL_W`, 4: bits per channel volume.
- `OUT_W`, 16: output sample width. Must satisfy `OUT_W ≥ IN_W+VOL_W`.

**Ports**
- `clk_sys`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `ce_sample`, in, 1: sample strobe, one cycle wide.
- `ch_in`, in, `CHANNELS*IN_W`: channel samples; channel i is at `[i*IN_W +: IN_W]`.
- `ch_signed`, in, `CHANNELS`: 1 means the sample is two's complement; 0 means offset-binary unsigned.
- `ch_vol`, in, `CHANNELS*VOL_W`: unsigned gain, 0 = silent.
- `ch_pan`, in, `CHANNELS*2`: bit `2i` enables channel i to L, bit `2i+1` enables it to R.
- `mute`, in, 1: forces output samples to 0.
- `out_l`, out, `OUT_W`: signed left sample, registered.
- `out_r`, out, `OUT_W`: signed right sample, registered.
- `out_valid`, out, 1: one-cycle pulse when `out_l`/`out_r` update.
- `clip_l`, out, 1: left saturated on the last update; valid with `out_valid` and held until the next update.
- `clip_r`, out, 1: right saturated on the last update; same timing as `clip_l`.
- `busy`, out, 1: high whenever the state is not IDLE.
- `overrun`, out, 1: one-cycle pulse when `ce_sample` arrives while busy.

## Operation
- FSM states: IDLE → ACCUM → SAT → IDLE.
- **IDLE**
  - `ce_sample=1`: snapshot `ch_in`, `ch_signed`, `ch_vol` and `ch_pan` into registers.
  - Clear `acc_l` and `acc_r`, set `idx=0`, go to ACCUM.
  - Inputs may change freely after the snapshot edge.
- **ACCUM**, one channel per clock:
  - Sample conversion: `s = ch_signed[idx] ? in : in − 2^(IN_W−1)`, signed `IN_W`.
  - Term: `t = (s × vol) <<< (OUT_W−IN_W−VOL_W)`, signed `OUT_W`. This never overflows.
  - Add `t` to `acc_l` if the L pan bit is set, and to `acc_r` if the R pan bit is set.
  - Accumulator width: `OUT_W + clog2(CHANNELS) + 1`.
  - After channel `CHANNELS−1`, go to SAT.
- **SAT**
  - Clamp each accumulator to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Set `clip_*` = clamp applied.
  - If `mute`, write 0 and clear `clip_*`.
  - Register `out_l`/`out_r`, pulse `out_valid`, return to IDLE.
- **Strobe handling**
  - `ce_sample` is accepted only in IDLE.
  - A strobe in ACCUM or SAT is dropped and pulses `overrun` on the next cycle.
  - There is no queueing.
- **Reset**
  - All outputs go to 0: `out_l`, `out_r`, `out_valid`, `clip_l`, `clip_r`, `busy`, `overrun`.
  - State returns to IDLE; accumulators and snapshot registers clear.
  - Reset mid-operation aborts the sample: no `out_valid`, and outputs stay 0.

## Timing
- Strobe accepted at edge k.
  - `busy` is high from k until edge k+CHANNELS+1.
  - Channels are accumulated at edges k+1 … k+CHANNELS.
  - SAT occurs at edge k+CHANNELS+1: outputs update and `out_valid` is high for the following cycle.
- Latency from strobe to valid is `CHANNELS+1` clocks.
- Maximum strobe rate is one per `CHANNELS+2` clocks.
- `overrun` is registered and is high in the cycle after the dropped strobe.

## Structure
- `audio_mix_pkg` holds:
  - the FSM state enum (IDLE, ACCUM, SAT);
  - the function `acc_width(CHANNELS, OUT_W)`;
  - the function `sat_signed`, a saturating narrow that returns value and clip flag.
- Sub-module `audio_mix_sat`: combinational saturator, parametrised by in/out widths, one instance per side.
- The top module `audio_mix_core` holds:
  - the FSM and the `idx` counter;
  - the snapshot registers;
  - one shared multiplier, muxed by `idx`.

## Test plan
All cases use default parameters.
1. **Single channel:** ch0=0xFF unsigned, vol 15, pan L only; ch1–3=0x80 → `out_l`=30480 (0x7710), `out_r`=0, `out_valid` 5 clocks after the strobe, `clip_l`=0.
2. **Positive saturation:** all channels 0xFF, vol 15, pan both → `out_l`=`out_r`=32767, `clip_l`=`clip_r`=1.
3. **Negative saturation and signed mode:**
   - All channels 0x00 unsigned, vol 15 → −32768 both sides, clip set.
   - ch0 `ch_signed`=1 with 0x80, vol 1, L only → `out_l`=−2048.
4. **Overrun:** strobe at k and k+2 → one `out_valid` only, `overrun` pulse at k+3, result reflects the k snapshot.
5. **Mute and zero volume:** case-2 stimulus with `mute`=1 → outputs 0, clips 0. `ch_vol`=0 on all channels → outputs 0.
6. **Reset mid-sample:** `reset` pulsed at k+2 → no `out_valid`, all outputs 0. A fresh strobe afterwards completes normally in 5 clocks.
